uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver (8N1, LSB first) for the UART/IrDA link.
//  Recovers bytes from the idle-high rx line using a 16x oversampling tick derived from the system clock.
//  Presents each byte with a 1-cycle valid strobe to the downstream consumer, and flags framing errors.
// PARAMETERS
//  CLK_HZ      50000000  system clock frequency
//  BAUD        9600      line bit rate
//  OVERSAMPLE  16        samples per bit (must be >= 8, even)
//  DATA_BITS   8         payload bits per frame
//  TICK_DIV    CLK_HZ/(BAUD*OVERSAMPLE) = 325 (integer truncation); clocks per sample tick
// PORTS
//  clock       in   1          system clock, all logic on posedge
//  reset       in   1          synchronous, active-high
//  rx          in   1          serial line, asynchronous to clock, idle = 1
//  data_out    out  DATA_BITS  last correctly framed byte; holds until the next good frame
//  data_valid  out  1          1-cycle pulse; data_out is new this cycle
//  frame_err   out  1          1-cycle pulse; stop bit sampled 0
//  busy        out  1          1 while the FSM is not in IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; data_out=0, data_valid=0, frame_err=0, busy=0; tick/sample/bit counters=0.
//  - rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s (2-cycle input latency).
//  - Tick counter: counts 0..TICK_DIV-1; tick=1 for one clock when count==TICK_DIV-1, then wraps to 0.
//    Forced to 0 on the IDLE->START transition so that sampling is phase-aligned to the start edge.
//  - Sample counter (4b): increments on each tick and wraps at OVERSAMPLE-1 -> 0.
//    Bit sample point: majority of rx_s at sample counts 7, 8 and 9 (mid-bit), evaluated at count 9.
//  - FSM:
//    IDLE : rx_s==0 -> START (clear the counters). Otherwise stay.
//    START: at count 9, majority==1 -> IDLE (false start/glitch, no pulse); else -> DATA, bit_cnt=0.
//    DATA : at each count 9, shift majority into bit DATA_BITS-1 of the shift register (shifting right);
//           bit_cnt++; after bit_cnt==DATA_BITS-1 is sampled -> STOP.
//    STOP : at count 9, majority==1 -> data_out<=shift, data_valid=1 for one clock, -> IDLE.
//           majority==0 -> frame_err=1 for one clock, data_out unchanged, -> BREAK.
//    BREAK: wait for rx_s==1 (line released), then -> IDLE. No re-arm on a held-low line.
//  - Latency: data_valid rises 1 clock after the stop-bit count-9 tick (~9.6 bit times after the start edge).
//  - Back-to-back frames: returning to IDLE at mid-stop lets the next falling edge be caught with no gap.
//  - data_valid and frame_err are never high in the same cycle; each is high for exactly 1 clock per frame.
//  - Reset mid-frame: abort immediately; no pulse; next frame requires a fresh start edge.
//  - Tolerance: correct reception for a sender baud error up to +/-3%.
//  - busy = (state != IDLE).
// STRUCTURE
//  - Shared package/include (uart_defs): state encodings (IDLE, START, DATA, STOP, BREAK),
//    TICK_DIV computation, and DATA_BITS/OVERSAMPLE defaults shared with uart_tx.
//  - Sub-module rx_tick_gen: parameterised divider with a sync clear input and a 1-cycle tick output.
//  - Top module: synchronizer, sample counter, 3-sample majority, FSM, shift register, output registers.
// TESTING
//  1. Send 0x55 at 9600 baud -> one data_valid pulse, data_out=0x55, frame_err stays 0.
//  2. Pull rx low for 3 ticks (~975 clocks), then high -> no data_valid, no frame_err, busy returns 0.
//  3. Send 0xA3 with stop bit=0, then release rx -> frame_err pulse, data_out keeps its previous value, FSM returns to IDLE.
//  4. Send 0x00 then 0xFF back-to-back (no idle bits) -> two data_valid pulses carrying 0x00 and 0xFF.
//  5. Assert reset midway through the data bits of 0x3C, release, then send 0x81 -> only 0x81 is reported; outputs are 0 during reset.
//  6. Send 0xC6 at BAUD*1.03 and at BAUD*0.97 -> data_out=0xC6 in both cases.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART definitions: receiver states, defaults, tick divider math
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    localparam int DEF_CLK_HZ     = 50000000;
    localparam int DEF_BAUD       = 9600;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    function automatic int tick_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// rtl/uart_rx_tick_gen.sv - oversampling tick divider with synchronous clear
module uart_rx_tick_gen #(
    parameter int DIV = 325
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == W'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == W'(DIV - 1)) && !clear;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 LSB-first UART receiver with 3-sample mid-bit majority voting
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_DIV = tick_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] SAMP_A   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_B   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_MID = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SAMP_TOP = SW'(OVERSAMPLE - 1);

    rx_state_t state, state_next;

    logic                 rx_m, rx_s;
    logic                 tick;
    logic [SW-1:0]        sample_cnt;
    logic                 samp_a, samp_b;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 mid_tick, majority, last_bit;
    logic                 load_out, err_set;

    // Divider is held cleared in IDLE so the first tick is phase-aligned to the start edge.
    uart_rx_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    assign mid_tick = tick && (sample_cnt == SAMP_MID);
    assign majority = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign last_bit = (bit_cnt == BW'(DATA_BITS - 1));
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE:  if (!rx_s) state_next = ST_START;
            ST_START: if (mid_tick) state_next = majority ? ST_IDLE : ST_DATA;
            ST_DATA:  if (mid_tick && last_bit) state_next = ST_STOP;
            ST_STOP: begin
                if (mid_tick) begin
                    if (majority) begin
                        load_out   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        err_set    = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: if (rx_s) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            sample_cnt <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            bit_cnt    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            data_valid <= load_out;
            frame_err  <= err_set;
            if (load_out) begin
                data_out <= shift;
            end
            if (state == ST_IDLE) begin
                sample_cnt <= '0;
            end else if (tick) begin
                sample_cnt <= (sample_cnt == SAMP_TOP) ? '0 : sample_cnt + SW'(1);
            end
            if (tick && sample_cnt == SAMP_A) samp_a <= rx_s;
            if (tick && sample_cnt == SAMP_B) samp_b <= rx_s;
            // LSB arrives first, so shifting right leaves it in bit 0 after the last data bit.
            if (state == ST_START) begin
                bit_cnt <= '0;
            end else if (state == ST_DATA && mid_tick) begin
                shift   <= {majority, shift[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

    localparam int CLK_HZ = 614400;
    localparam int BAUD   = 9600;
    localparam int BIT_T  = 640;
    localparam int FAST_T = 621;
    localparam int SLOW_T = 660;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, busy;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_out = 8'h00;
    logic       rst_seen  = 1'b1;
    int         passed    = 0;
    int         total     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clock) rst_seen <= reset;

    always @(negedge clock) begin
        if (rst_seen) begin
            model_out = 8'h00;
            check("reset_outputs", {data_out, data_valid, frame_err, busy}, 32'h0);
        end else begin
            if (data_valid && frame_err) check("valid_and_err", 1, 0);
            if (data_valid || frame_err) begin
                check("pulse_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", frame_err, e.is_err);
                    if (!e.is_err) begin
                        check("rx_byte", data_out, e.data);
                        model_out = e.data;
                    end
                end
            end
            check("data_out_hold", data_out, model_out);
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit stop, input int bit_t, input bit expect_ev);
        ev_t e;
        if (expect_ev) begin
            e.is_err = !stop;
            e.data   = b;
            exp_q.push_back(e);
        end
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop;
        #(bit_t);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idle_check_busy(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(posedge clock);
        @(negedge clock);
        check("busy_idle", busy, 0);
    endtask

    task automatic align;
        @(posedge clock);
        #2;
    endtask

    initial begin
        logic [7:0] rb;
        int         bt;
        bit         good;

        repeat (4) @(posedge clock);
        @(negedge clock);
        check("reset_data_out", data_out, 8'h00);
        check("reset_busy", busy, 0);
        align;
        reset = 1'b0;
        repeat (20) @(posedge clock);

        align;
        send_frame(8'h55, 1'b1, BIT_T, 1'b1);
        drain("drain_55");
        @(negedge clock);
        check("lit_55", data_out, 8'h55);
        idle_check_busy(40);

        align;
        rx = 1'b0;
        #120;
        rx = 1'b1;
        idle_check_busy(150);
        check("glitch_no_event", exp_q.size(), 0);

        align;
        send_frame(8'hA3, 1'b0, BIT_T, 1'b1);
        #(2 * BIT_T);
        rx = 1'b1;
        drain("drain_ferr");
        @(negedge clock);
        check("lit_keep_55", data_out, 8'h55);
        idle_check_busy(100);

        align;
        send_frame(8'h00, 1'b1, BIT_T, 1'b1);
        send_frame(8'hFF, 1'b1, BIT_T, 1'b1);
        drain("drain_b2b");
        @(negedge clock);
        check("lit_ff", data_out, 8'hFF);
        idle_check_busy(40);

        align;
        fork
            send_frame(8'h3C, 1'b1, BIT_T, 1'b0);
            begin
                #(4 * BIT_T);
                align;
                reset = 1'b1;
            end
        join
        rx = 1'b1;
        repeat (3) @(posedge clock);
        align;
        reset = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        check("lit_after_reset", data_out, 8'h00);
        align;
        send_frame(8'h81, 1'b1, BIT_T, 1'b1);
        drain("drain_81");
        @(negedge clock);
        check("lit_81", data_out, 8'h81);
        idle_check_busy(40);

        align;
        send_frame(8'hC6, 1'b1, FAST_T, 1'b1);
        drain("drain_fast");
        @(negedge clock);
        check("lit_c6_fast", data_out, 8'hC6);
        idle_check_busy(40);
        align;
        send_frame(8'h11, 1'b1, BIT_T, 1'b1);
        idle_check_busy(20);
        align;
        send_frame(8'hC6, 1'b1, SLOW_T, 1'b1);
        drain("drain_slow");
        @(negedge clock);
        check("lit_c6_slow", data_out, 8'hC6);
        idle_check_busy(40);

        for (int k = 0; k < 10; k++) begin
            rb   = 8'($urandom_range(0, 255));
            bt   = int'($urandom_range(628, 652));
            good = ($urandom_range(0, 5) != 0);
            align;
            send_frame(rb, good, bt, 1'b1);
            if (!good) begin
                #(int'($urandom_range(1, 3)) * BIT_T);
                rx = 1'b1;
                drain("drain_rand_err");
                idle_check_busy(80);
            end else if ($urandom_range(0, 1) == 1) begin
                drain("drain_rand");
            end else begin
                rx = 1'b1;
                #(int'($urandom_range(1, 3)) * BIT_T);
                drain("drain_rand_gap");
            end
        end
        idle_check_busy(80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
